// File: rtl/spinner_pkg.sv
// Shared constants and types for the spinner decoder: fixed-point widths,
// digital step sizes and the joystick-emulation state enum.
package spinner_pkg;

  localparam int FINE_W = 11;
  localparam int FRAC_W = 3;
  localparam int POS_W  = FINE_W - FRAC_W;
  localparam int STEP_W = 4;

  localparam logic [STEP_W-1:0] STEP_SLOW = 4'd1;
  localparam logic [STEP_W-1:0] STEP_MED  = 4'd2;
  localparam logic [STEP_W-1:0] STEP_FAST = 4'd4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } dig_state_e;

endpackage

// File: rtl/spinner_decoder_dig_ramp.sv
// Digital spinner emulation: a held joystick direction produces signed steps
// every DIG_PERIOD cycles whose size ramps 1 -> 2 -> 4 pos units.
module dig_ramp
  import spinner_pkg::*;
#(
  parameter int DIG_PERIOD = 200000,
  parameter int RAMP_STEPS = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     left_i,
  input  logic                     right_i,
  output logic signed [STEP_W-1:0] step_o
);

  localparam int CNT_W = (DIG_PERIOD > 1) ? $clog2(DIG_PERIOD) : 1;
  localparam int RMP_W = $clog2(2 * RAMP_STEPS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIG_PERIOD - 1);
  localparam logic [RMP_W-1:0] RMP_MED  = RMP_W'(RAMP_STEPS);
  localparam logic [RMP_W-1:0] RMP_MAX  = RMP_W'(2 * RAMP_STEPS);

  dig_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RMP_W-1:0] ramp_q, ramp_d;
  logic             hold_left_q, hold_left_d;
  logic             one_s, keep_s;
  logic [STEP_W-1:0] mag_s;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ramp_q      <= '0;
      hold_left_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ramp_q      <= ramp_d;
      hold_left_q <= hold_left_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ramp_d      = ramp_q;
    hold_left_d = hold_left_q;
    step_o      = '0;
    one_s       = left_i ^ right_i;
    keep_s      = one_s && (left_i == hold_left_q);
    if (ramp_q < RMP_MED) begin
      mag_s = STEP_SLOW;
    end else if (ramp_q < RMP_MAX) begin
      mag_s = STEP_MED;
    end else begin
      mag_s = STEP_FAST;
    end
    case (state_q)
      ST_IDLE: begin
        cnt_d  = '0;
        ramp_d = '0;
        if (one_s) begin
          state_d     = ST_HOLD;
          hold_left_d = left_i;
        end
      end
      ST_HOLD: begin
        // A reversal drops to IDLE so the ramp restarts from the slow size.
        if (!keep_s) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          ramp_d  = '0;
        end else begin
          cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
          if (cnt_q == '0) begin
            step_o = hold_left_q ? (STEP_W'(0) - mag_s) : mag_s;
            if (ramp_q < RMP_MAX) begin
              ramp_d = ramp_q + RMP_W'(1);
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/spinner_decoder.sv
// Spinner position decoder: host delta words plus ramped joystick emulation
// into a wrapped 8-bit position. Optional macro SPINNER_SENS_EN adds a sens port.
module spinner_decoder
  import spinner_pkg::*;
#(
  parameter int DIG_PERIOD = 200000,
  parameter int RAMP_STEPS = 8
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic [8:0]       spinner_in,
  input  logic             joy_left,
  input  logic             joy_right,
`ifdef SPINNER_SENS_EN
  input  logic [1:0]       sens,
`endif
  output logic [POS_W-1:0] pos,
  output logic             moved,
  output logic             dir
);

  logic [8:0]              s_q;
  logic                    t_prev_q, primed_q;
  logic [FINE_W-1:0]       fine_q, fine_d;
  logic                    dir_fine_q, dir_fine_d;
  logic [POS_W-1:0]        pos_q, pos_d;
  logic                    moved_q, dir_q;
  logic                    event_s;
  logic [1:0]              shamt_s;
  logic signed [STEP_W-1:0] step_s;
  logic signed [FINE_W:0]  delta_ext_s, ana_s, dig_s, sum_s;

  dig_ramp #(
    .DIG_PERIOD(DIG_PERIOD),
    .RAMP_STEPS(RAMP_STEPS)
  ) u_dig_ramp (
    .clk_i  (clk_sys),
    .rst_i  (reset),
    .left_i (joy_left),
    .right_i(joy_right),
    .step_o (step_s)
  );

  always_comb begin
`ifdef SPINNER_SENS_EN
    shamt_s = 2'd3 - sens;
`else
    shamt_s = 2'd3;
`endif
    event_s     = primed_q && (s_q[8] != t_prev_q);
    delta_ext_s = {{(FINE_W + 1 - 8){s_q[7]}}, s_q[7:0]};
    ana_s       = event_s ? (delta_ext_s << shamt_s) : '0;
    dig_s       = {{(FINE_W + 1 - STEP_W){step_s[STEP_W-1]}}, step_s} << FRAC_W;
    sum_s       = ana_s + dig_s;
    fine_d      = fine_q + sum_s[FINE_W-1:0];
    dir_fine_d  = (sum_s == '0) ? dir_fine_q : sum_s[FINE_W];
    pos_d       = fine_q[FINE_W-1:FRAC_W];
  end

  // s_q keeps sampling through reset so t_prev can be primed from a valid bit.
  always_ff @(posedge clk_sys) begin
    s_q <= spinner_in;
    if (reset) begin
      t_prev_q   <= 1'b0;
      primed_q   <= 1'b0;
      fine_q     <= '0;
      dir_fine_q <= 1'b0;
      pos_q      <= '0;
      moved_q    <= 1'b0;
      dir_q      <= 1'b0;
    end else begin
      t_prev_q   <= s_q[8];
      primed_q   <= 1'b1;
      fine_q     <= fine_d;
      dir_fine_q <= dir_fine_d;
      pos_q      <= pos_d;
      moved_q    <= (pos_d != pos_q);
      dir_q      <= dir_fine_q;
    end
  end

  assign pos   = pos_q;
  assign moved = moved_q;
  assign dir   = dir_q;

endmodule

// File: tb/tb_spinner_decoder.sv
// Self-checking bench for spinner_decoder: directed scenarios plus random
// host deltas against a fixed-point position model.
module tb_spinner_decoder;

  localparam int P = 4;
  localparam int R = 8;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic [8:0] spinner_in;
  logic       joy_left, joy_right;
  logic [7:0] pos;
  logic       moved, dir;
`ifdef SPINNER_SENS_EN
  logic [1:0] sens;
`endif

  int checks = 0;
  int errors = 0;

  // model state
  int   m_fine;
  bit   m_dir;
  int   last_pos;
  int   pipe_pos[$];
  bit   pipe_dir[$];
  logic tog;

  spinner_decoder #(.DIG_PERIOD(P), .RAMP_STEPS(R)) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .spinner_in(spinner_in),
    .joy_left  (joy_left),
    .joy_right (joy_right),
`ifdef SPINNER_SENS_EN
    .sens      (sens),
`endif
    .pos       (pos),
    .moved     (moved),
    .dir       (dir)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic int wrapm(input int x, input int m);
    return ((x % m) + m) % m;
  endfunction

  function automatic int ana_shift();
`ifdef SPINNER_SENS_EN
    return 3 - int'(sens);
`else
    return 3;
`endif
  endfunction

  function automatic int step_size(input int k);
    if (k <= R) return 1;
    if (k <= 2 * R) return 2;
    return 4;
  endfunction

  // total pos units visible c edges after the joystick was driven
  function automatic int steps_sum(input int c, input int lag);
    int n, s;
    s = 0;
    n = (c < lag) ? 0 : (c - lag) / P + 1;
    for (int k = 1; k <= n; k++) s += step_size(k);
    return s;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic settle_pipe();
    pipe_pos.delete(); pipe_dir.delete();
    repeat (2) begin
      pipe_pos.push_back(m_fine / 8);
      pipe_dir.push_back(m_dir);
    end
    last_pos = m_fine / 8;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1; joy_left = 1'b0; joy_right = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk_sys); #1;
      chk("rst_pos", int'(pos), 0);
      chk("rst_moved", int'(moved), 0);
      chk("rst_dir", int'(dir), 0);
    end
    reset = 1'b0;
    m_fine = 0; m_dir = 1'b0;
    settle_pipe();
  endtask

  // one cycle of host input (optionally toggling) plus a coincident digital step
  task automatic step_an(input bit tg, input logic [7:0] d, input int dig, input string tag);
    int contrib, ep;
    bit ed;
    if (tg) tog = ~tog;
    spinner_in = {tog, d};
    contrib = tg ? int'($signed(d)) * (1 << ana_shift()) : 0;
    contrib += dig * 8;
    m_fine = wrapm(m_fine + contrib, 2048);
    if (contrib != 0) m_dir = (contrib < 0);
    pipe_pos.push_back(m_fine / 8);
    pipe_dir.push_back(m_dir);
    @(posedge clk_sys); #1;
    ep = pipe_pos.pop_front();
    ed = pipe_dir.pop_front();
    chk({tag, "_pos"}, int'(pos), ep);
    chk({tag, "_moved"}, int'(moved), int'(ep != last_pos));
    chk({tag, "_dir"}, int'(dir), int'(ed));
    last_pos = ep;
  endtask

  // joystick level held for ncyc cycles; lag = edges until the first step shows
  task automatic run_hold(input bit l, input bit r, input int lag, input int ncyc, input string tag);
    int base, s, sprev, sg;
    base = m_fine; sprev = 0;
    sg = (l && !r) ? -1 : ((r && !l) ? 1 : 0);
    joy_left = l; joy_right = r;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk_sys); #1;
      s = (sg == 0) ? 0 : steps_sum(c, lag);
      m_fine = wrapm(base + sg * s * 8, 2048);
      if (s != 0) m_dir = (sg < 0);
      chk({tag, "_pos"}, int'(pos), m_fine / 8);
      chk({tag, "_moved"}, int'(moved), int'(s != sprev));
      chk({tag, "_dir"}, int'(dir), int'(m_dir));
      sprev = s;
    end
    settle_pipe();
  endtask

  initial begin
    reset = 1'b1; tog = 1'b0; spinner_in = 9'h005;
    joy_left = 1'b0; joy_right = 1'b0;
`ifdef SPINNER_SENS_EN
    sens = 2'd0;
`endif
    m_fine = 0; m_dir = 1'b0;
    do_reset(3);

    // first toggle after reset: pos appears two edges after capture
    repeat (3) step_an(1'b0, 8'h05, 0, "hold005");
    step_an(1'b1, 8'h05, 0, "tog005");
    repeat (3) step_an(1'b0, 8'h05, 0, "after005");

    // negative delta, wrap up and down, zero delta
    step_an(1'b1, 8'hFD, 0, "to2");
    repeat (2) step_an(1'b0, 8'h11, 0, "q1");
    step_an(1'b1, 8'hFB, 0, "neg5");
    repeat (3) step_an(1'b0, 8'h22, 0, "q2");
    step_an(1'b1, 8'h03, 0, "wrap_up");
    repeat (2) step_an(1'b0, 8'h00, 0, "q3");
    step_an(1'b1, 8'hFF, 0, "wrap_dn");
    repeat (2) step_an(1'b0, 8'h00, 0, "q4");
    step_an(1'b1, 8'h00, 0, "zero");
    repeat (3) step_an(1'b0, 8'h00, 0, "q5");

    // host +3 coincident with a single left step
    joy_left = 1'b1;
    step_an(1'b1, 8'h03, -1, "coinc");
    step_an(1'b0, 8'h00, 0, "coinc_h");
    joy_left = 1'b0;
    repeat (4) step_an(1'b0, 8'h00, 0, "coinc_q");

    for (int i = 0; i < 150; i++)
      step_an(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 0, "rnd");
    repeat (2) step_an(1'b0, 8'h00, 0, "rnd_q");

    // reset with an event in flight discards it
    step_an(1'b1, 8'h40, 0, "pend");
    do_reset(2);
    repeat (3) step_an(1'b0, 8'h40, 0, "post_rst");

    run_hold(1'b0, 1'b1, 2, 79, "ramp");
    chk("ramp_final", int'(pos), 40);
    run_hold(1'b0, 1'b0, 2, 8, "rel");
    run_hold(1'b0, 1'b1, 2, 43, "pre_rev");
    run_hold(1'b1, 1'b0, 3, 10, "rev");
    run_hold(1'b0, 1'b0, 2, 6, "rel2");
    run_hold(1'b1, 1'b1, 2, 100, "both");
    run_hold(1'b0, 1'b0, 2, 4, "rel3");
    repeat (2) step_an(1'b0, 8'h00, 0, "end_q");

`ifdef SPINNER_SENS_EN
    do_reset(2);
    sens = 2'd3;
    repeat (2) step_an(1'b0, 8'h00, 0, "sens_q");
    for (int i = 0; i < 8; i++) begin
      step_an(1'b1, 8'h01, 0, "sens_tog");
      step_an(1'b0, 8'h01, 0, "sens_idle");
    end
    repeat (2) step_an(1'b0, 8'h01, 0, "sens_end");
    chk("sens_final", int'(pos), 1);
    sens = 2'd0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
